// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream program loader that writes 20-bit instruction words and releases the CPU after a verified checksum
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [19:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_run
);
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
  typedef enum logic [3:0] {IDLE, LEN_LO, LEN_HI, B0, B1, B2, CHK, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [7:0] len_lo_q, len_lo_d, chk_q, chk_d;
  logic [15:0] lo_q, lo_d;
  logic [ADDR_W:0] rem_q, rem_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [19:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d, run_q, run_d;
  logic acc;
  logic [15:0] n;
  assign in_ready = state_q inside {LEN_LO, LEN_HI, B0, B1, B2, CHK};
  assign acc = in_valid && in_ready;
  assign n = {in_data, len_lo_q};
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign cpu_run = run_q;
  // next-state: stream parsing, word assembly, checksum and status flags
  always_comb begin
    state_d = state_q;
    len_lo_d = len_lo_q;
    lo_d = lo_q;
    rem_d = rem_q;
    wr_en_d = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;
    chk_d = acc ? chk_q ^ in_data : chk_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    run_d = run_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LEN_LO;
        busy_d = 1'b1;
        done_d = 1'b0;
        err_d = 1'b0;
        run_d = 1'b0;
        wr_addr_d = '0;
        chk_d = '0;
      end
      LEN_LO: if (acc) begin
        len_lo_d = in_data;
        state_d = LEN_HI;
      end
      LEN_HI: if (acc) begin
        if (n == '0 || {1'b0, n} > DEPTH) begin
          state_d = ERR;
          err_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          rem_d = n[ADDR_W:0];
          state_d = B0;
        end
      end
      B0: if (acc) begin
        lo_d[7:0] = in_data;
        state_d = B1;
      end
      B1: if (acc) begin
        lo_d[15:8] = in_data;
        state_d = B2;
      end
      B2: if (acc) begin
        if (in_data[7:4] != 4'd0) begin
          state_d = ERR;
          err_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          wr_en_d = 1'b1;
          wr_data_d = {in_data[3:0], lo_q};
          rem_d = rem_q - 1'b1;
          state_d = rem_q == {{ADDR_W{1'b0}}, 1'b1} ? CHK : B0;
        end
      end
      CHK: if (acc) begin
        busy_d = 1'b0;
        if (in_data == chk_q) begin
          state_d = DONE;
          done_d = 1'b1;
          run_d = 1'b1;
        end else begin
          state_d = ERR;
          err_d = 1'b1;
          run_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset aborts any load and cancels a pending write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_lo_q <= '0;
      lo_q <= '0;
      rem_q <= '0;
      chk_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_lo_q <= len_lo_d;
      lo_q <= lo_d;
      rem_q <= rem_d;
      chk_q <= chk_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      run_q <= run_d;
    end
  end
endmodule
